// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// The transmit side draws its frame constants from here as well.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        START_BIT      = 1'b0;
  localparam logic        STOP_BIT       = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// It resets to 1 so that the line reads as idle while reset is held.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled mid-bit, delivered through a one-entry
// valid/ready holding register, with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic                      rx_ready,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic                      busy
);

  localparam int unsigned      DATA_BITS = UART_DATA_BITS;
  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned      HALF      = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 done_q;
  logic                 half_tick, bit_tick;
  logic                 shift_en, done_c, ferr_c;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and sample strobes.
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    done_c    = 1'b0;
    ferr_c    = 1'b0;
    half_tick = (baud_cnt == HALF_LAST);
    bit_tick  = (baud_cnt == BIT_LAST);
    case (state_q)
      IDLE: begin
        if (rx_s == START_BIT) state_d = START;
      end
      START: begin
        if (half_tick) state_d = (rx_s == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (rx_s == STOP_BIT) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s == STOP_BIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing: restart on each state entry and after every data sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if ((state_d != state_q) || shift_en || (state_q == IDLE) || (state_q == WAIT_HIGH))
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CNT_W'(1);

      if (state_q != DATA)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 3'd1;

      if (shift_en)
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  // Holding register: a completed byte lands one cycle after the stop sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      frame_err   <= ferr_c;
      done_q      <= done_c;
      overrun_err <= 1'b0;
      busy        <= (state_d != IDLE);
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit and
// delivered bytes are matched against a queue of expected values.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 8;
  // Cycles from driving the start bit to rx_valid rising (2 sync + 1 detect + 77).
  localparam int unsigned LAT = 3 + CPB / 2 + 9 * CPB + 1;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx_in    = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_start = 0;
  int   rise_cyc = 0;
  int   ovr_cyc = 0;
  int   valid_cycles = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] sb[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor and scoreboard pop on each accepted transfer.
  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
    if (frame_err) ferr_cnt++;
    if (overrun_err) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (rx_valid && rx_ready) begin
      check_eq("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check_eq("rx_data", 32'(rx_data), 32'(sb.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(posedge clk);
    #1;
    last_start = cyc;
    drive_bit(START_BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic clear_counts();
    valid_cycles = 0;
    ferr_cnt     = 0;
    ovr_cnt      = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    #2 reset = 1'b0;
    idle(3);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overrun_err", 32'(overrun_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(4);

    // Basic frame with downstream always ready.
    clear_counts();
    rx_ready = 1'b1;
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    t0 = last_start;
    idle(8);
    check_eq("a5_latency", 32'(rise_cyc - t0), 32'(LAT));
    check_eq("a5_valid_cycles", 32'(valid_cycles), 32'd1);
    check_eq("a5_frame_err", 32'(ferr_cnt), 32'd0);
    check_eq("a5_overrun", 32'(ovr_cnt), 32'd0);

    // Two-cycle glitch: false start rejected at the half-bit sample.
    clear_counts();
    @(posedge clk);
    #1;
    t0 = cyc;
    rx_in = 1'b0;
    idle(2);
    rx_in = 1'b1;
    wait_until(t0 + 6);
    check_eq("glitch_busy_start", 32'(busy), 32'd1);
    wait_until(t0 + 7);
    check_eq("glitch_busy_idle", 32'(busy), 32'd0);
    idle(20);
    check_eq("glitch_valid", 32'(valid_cycles), 32'd0);
    check_eq("glitch_frame_err", 32'(ferr_cnt), 32'd0);

    // Bad stop bit, then a good frame.
    clear_counts();
    send_byte(8'h3C, 1'b0);
    idle(4);
    sb.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    idle(8);
    check_eq("ferr_pulses", 32'(ferr_cnt), 32'd1);
    check_eq("ferr_valid_cycles", 32'(valid_cycles), 32'd1);
    check_eq("ferr_overrun", 32'(ovr_cnt), 32'd0);
    check_eq("ferr_busy", 32'(busy), 32'd0);

    // Overrun: second byte dropped while the first is held.
    clear_counts();
    rx_ready = 1'b0;
    sb.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    t0 = last_start;
    idle(4);
    check_eq("ovr_pulses", 32'(ovr_cnt), 32'd1);
    check_eq("ovr_timing", 32'(ovr_cyc - t0), 32'(LAT));
    check_eq("ovr_held_data", 32'(rx_data), 32'h11);
    check_eq("ovr_held_valid", 32'(rx_valid), 32'd1);
    check_eq("ovr_frame_err", 32'(ferr_cnt), 32'd0);
    rx_ready = 1'b1;
    idle(1);
    check_eq("ovr_valid_falls", 32'(rx_valid), 32'd0);

    // Ready raised exactly in the delivery cycle of the second byte.
    clear_counts();
    rx_ready = 1'b0;
    sb.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    sb.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_until(last_start + int'(LAT) - 2);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check_eq("swap_valid", 32'(rx_valid), 32'd1);
        check_eq("swap_data", 32'(rx_data), 32'h22);
      end
    join
    idle(4);
    check_eq("swap_overrun", 32'(ovr_cnt), 32'd0);
    rx_ready = 1'b1;
    idle(3);
    check_eq("swap_drained", 32'(sb.size()), 32'd0);

    // Reset mid-frame clears everything, including a held byte.
    clear_counts();
    rx_ready = 1'b0;
    send_byte(8'h33, 1'b1);
    idle(2);
    check_eq("pre_rst_valid", 32'(rx_valid), 32'd1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        @(posedge clk);
        #2;
        wait_until(last_start + 42);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_eq("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("midrst_rx_data", 32'(rx_data), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_frame_err", 32'(frame_err), 32'd0);
        check_eq("midrst_overrun", 32'(overrun_err), 32'd0);
      end
    join
    rx_in = 1'b1;
    idle(4);
    reset = 1'b1;
    idle(4);
    clear_counts();
    rx_ready = 1'b1;
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle(8);
    check_eq("post_rst_valid_cycles", 32'(valid_cycles), 32'd1);
    check_eq("post_rst_frame_err", 32'(ferr_cnt), 32'd0);
    check_eq("post_rst_overrun", 32'(ovr_cnt), 32'd0);
    check_eq("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
